rr_arbiter_4: RTL
=================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter sharing a single downstream resource.
- Grant is one-hot plus a 2-bit encoded index, consumed directly as a mux select.
- Owner keeps the grant until it releases, drops its request, or exceeds a hold limit.
- Sits in front of the shared datapath and serves as its sequencing and fairness controller.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per owner before forced release; 0 disables the limit.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i] high means requester i wants the resource.
- rel  input  1  release strobe from the current owner; ignored when no grant is active.
- gnt  output  4  one-hot grant, registered.
- gnt_idx  output  2  binary index of the set gnt bit; 0 when gnt is 0.
- gnt_vld  output  1  high whenever gnt is non-zero.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD.

Behaviour:
- Reset (synchronous, on the clk edge with rst=1) clears everything, overriding all other inputs:
  - gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
  - Internal ptr=0, hold_cnt=0, state=IDLE.
- Internal state:
  - Two-state FSM: IDLE and GRANT.
  - ptr[1:0] is the highest-priority candidate.
  - hold_cnt is $clog2(MAX_HOLD+1) bits wide, minimum 1 bit.
- IDLE:
  - If req != 0, choose the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
  - Next edge: gnt=onehot(i), gnt_idx=i, gnt_vld=1, hold_cnt=1, state=GRANT.
  - Latency from req sampled high to gnt visible is 1 cycle.
  - If req=0, remain in IDLE with all outputs 0.
- GRANT: let o = gnt_idx. The grant ends on the next edge if any of these holds:
  - (a) rel=1;
  - (b) req[o]=0;
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
- On ending the grant:
  - gnt=0, gnt_idx=0, gnt_vld=0.
  - ptr=o+1 (wraps 3→0), hold_cnt=0, state=IDLE.
  - timeout=1 for exactly that one cycle only if (c) alone caused the release. If (a) or (b) also holds, timeout stays 0.
- Otherwise: hold_cnt increments and the grant is unchanged.
  - Changes on other req bits never preempt the owner.
- The grant is held for at most MAX_HOLD consecutive cycles.
- One mandatory idle cycle (gnt=0) separates any two grants. There is no back-to-back handoff.
- rel arriving in IDLE has no effect.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_idx always equals the encoded gnt.
  - gnt_vld == |gnt.
  - timeout is never high in two consecutive cycles.
- Fairness: any requester holding req continuously is granted within 3 grant periods of other requesters.
- Reset mid-grant: the next edge with rst=1 clears the grant immediately with no timeout pulse, and ptr returns to 0.

Test Plan:
- Reset: assert rst for 2 cycles with req=1111 → gnt=0000, gnt_idx=0, gnt_vld=0, timeout=0 throughout; the first grant after rst drops is gnt=0001.
- Single request: req=0100 at cycle N → gnt=0100, gnt_idx=2, gnt_vld=1 at N+1. Pulse rel at N+3 → gnt=0000 at N+4, timeout stays 0.
- Rotation: req=1111 held, rel pulsed on each grant's first cycle → grant order 0,1,2,3,0, each grant lasting 1 cycle and separated by 1 idle cycle.
- Skip and wrap: after owner 0 releases, req=1001 → gnt_idx=3. After 3 releases with req=1001 → gnt_idx=0.
- Timeout (MAX_HOLD=8): req=0010 held, rel=0 → gnt high for exactly 8 cycles, then gnt=0 with timeout=1 for 1 cycle, then gnt=0010 again on the following cycle. The same scenario with rel asserted on the 8th grant cycle gives timeout=0.
- Reset mid-grant and request drop:
  - Owner 2 granted, rst for 1 cycle → all outputs 0 next cycle; then req=1111 gives gnt=0001.
  - Separately, dropping req[o] while owning → gnt=0 next cycle, timeout=0.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter for one shared resource.
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   req     - request lines, req[i] high when requester i wants the resource
//   rel     - release strobe from the current owner (ignored while idle)
//   gnt     - registered one-hot grant
//   gnt_idx - binary index of the granted requester (0 when no grant)
//   gnt_vld - high whenever gnt is non-zero
//   timeout - one-cycle pulse when a grant is revoked by the hold limit
// The owner keeps the grant until it releases, drops its request, or hits
// MAX_HOLD consecutive cycles (0 disables the limit). Every grant is
// followed by one idle cycle before the next grant can start.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       rel,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
  localparam logic          LIMIT_EN   = (MAX_HOLD != 0);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [HW-1:0] hold_cnt;

  logic [1:0] pick_idx;
  logic       pick_vld;
  logic       end_rel;
  logic       end_drop;
  logic       end_lim;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      logic [1:0] cand;
      cand = ptr + 2'(k);
      if (!pick_vld && req[cand]) begin
        pick_idx = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    end_rel  = rel;
    end_drop = !req[gnt_idx];
    end_lim  = LIMIT_EN && (hold_cnt == HOLD_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt      <= 4'b0001 << pick_idx;
            gnt_idx  <= pick_idx;
            gnt_vld  <= 1'b1;
            hold_cnt <= HW'(1);
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (end_rel || end_drop || end_lim) begin
            gnt      <= '0;
            gnt_idx  <= '0;
            gnt_vld  <= 1'b0;
            ptr      <= gnt_idx + 2'd1;
            hold_cnt <= '0;
            state    <= IDLE;
            // Only a pure limit expiry counts as a forced revoke.
            timeout  <= end_lim && !end_rel && !end_drop;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
